// File: rtl/matrix_addr_gen_pkg.sv
// Shared constants and types for the matrix address sequencer.
package matrix_addr_gen_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_CNT_WIDTH  = 11;
    localparam int DEF_PIPE_DEPTH = 3;

    // Full bus width: word offset plus the two bank-select MSBs.
    localparam int BANKED_AW = DEF_ADDR_WIDTH + 2;

    localparam logic [1:0] BANK_M0P0 = 2'b00;
    localparam logic [1:0] BANK_M0P1 = 2'b01;
    localparam logic [1:0] BANK_M1P0 = 2'b10;
    localparam logic [1:0] BANK_M1P1 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int banked_width(input int aw);
        return aw + 2;
    endfunction

    function automatic logic banks_distinct(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c, input logic [1:0] d);
        return (a != b) && (a != c) && (a != d) && (b != c) && (b != d) && (c != d);
    endfunction

endpackage

// File: rtl/matrix_addr_gen_delay.sv
// Stall-aware valid+address shift register lining D writes up with datapath latency.
module addr_delay_line #(
    parameter int DEPTH = 3,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_vld,
    input  logic [AW-1:0]    i_addr,
    output logic [DEPTH-1:0] o_vld,
    output logic [AW-1:0]    o_addr
);

    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_addr [DEPTH];

    // Address stages only load behind a valid, so bubbles never disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) r_addr[k] <= '0;
        end else if (i_adv) begin
            r_vld[0] <= i_vld;
            if (i_vld) r_addr[0] <= i_addr;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) r_addr[k] <= r_addr[k-1];
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_addr = r_addr[DEPTH-1];

endmodule

// File: rtl/matrix_addr_gen.sv
// Row-major A/B/C read and delayed D write address sequencer for a ROWS x COLS tile.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; config sampled on start
//   ST_RUN   | one element issued per non-stalled cycle
//   ST_DRAIN | issue finished, waiting for D pipeline to empty
//   ST_DONE  | one-cycle done (and cfg_err) pulse
module matrix_addr_gen
    import matrix_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH+1:0] a_base,
    input  logic [ADDR_WIDTH+1:0] b_base,
    input  logic [ADDR_WIDTH+1:0] c_base,
    input  logic [ADDR_WIDTH+1:0] d_base,
    input  logic [ADDR_WIDTH-1:0] a_stride,
    input  logic [ADDR_WIDTH-1:0] c_stride,
    input  logic [ADDR_WIDTH-1:0] d_stride,
    input  logic [CNT_WIDTH-1:0]  rows,
    input  logic [CNT_WIDTH-1:0]  cols,
    input  logic                  stall,
    output logic [ADDR_WIDTH+1:0] A_addr,
    output logic [ADDR_WIDTH+1:0] B_addr,
    output logic [ADDR_WIDTH+1:0] C_addr,
    output logic [ADDR_WIDTH+1:0] D_addr,
    output logic                  rd_valid,
    output logic                  d_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int AW = ADDR_WIDTH;
    localparam int BW = banked_width(ADDR_WIDTH);
    localparam logic [PIPE_DEPTH-1:0] LAST_MASK = PIPE_DEPTH'(1) << (PIPE_DEPTH - 1);

    state_t r_state, w_state_nxt;

    logic [1:0]           r_bank_a, r_bank_b, r_bank_c, r_bank_d;
    logic [AW-1:0]        r_b_off, r_a_stride, r_c_stride, r_d_stride;
    logic [CNT_WIDTH-1:0] r_rows, r_cols, r_i, r_j;
    logic [AW-1:0]        r_a_row, r_c_row, r_d_row;
    logic [BW-1:0]        r_a_addr, r_b_addr, r_c_addr, r_d_issue, r_d_hold;
    logic                 r_cfg_err;

    logic                 w_start_ok, w_bank_ok, w_empty, w_issue, w_last_col, w_last;
    logic                 w_drain_ok, w_wr;
    logic [CNT_WIDTH-1:0] w_j_inc;
    logic [AW-1:0]        w_a_nxt, w_b_nxt, w_c_nxt, w_d_nxt;
    logic [PIPE_DEPTH-1:0] w_dl_vld;
    logic [BW-1:0]        w_dl_addr;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_bank_ok  = banks_distinct(a_base[AW+1:AW], b_base[AW+1:AW],
                                       c_base[AW+1:AW], d_base[AW+1:AW]);
    assign w_empty    = (rows == '0) || (cols == '0);
    assign w_issue    = (r_state == ST_RUN) && !stall;
    assign w_last_col = (r_j == r_cols - 1'b1);
    assign w_last     = w_last_col && (r_i == r_rows - 1'b1);
    assign w_j_inc    = r_j + 1'b1;

    // End of a row restarts each operand from its (advanced) row pointer.
    always_comb begin
        w_a_nxt = r_a_row + AW'(w_j_inc);
        w_b_nxt = r_b_off + AW'(w_j_inc);
        w_c_nxt = r_c_row + AW'(w_j_inc);
        w_d_nxt = r_d_row + AW'(w_j_inc);
        if (w_last_col) begin
            w_a_nxt = r_a_row + r_a_stride;
            w_b_nxt = r_b_off;
            w_c_nxt = r_c_row + r_c_stride;
            w_d_nxt = r_d_row + r_d_stride;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = (!w_bank_ok || w_empty) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_issue && w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_ok) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_a   <= '0;
            r_bank_b   <= '0;
            r_bank_c   <= '0;
            r_bank_d   <= '0;
            r_b_off    <= '0;
            r_a_stride <= '0;
            r_c_stride <= '0;
            r_d_stride <= '0;
            r_rows     <= '0;
            r_cols     <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_a_row    <= '0;
            r_c_row    <= '0;
            r_d_row    <= '0;
            r_a_addr   <= '0;
            r_b_addr   <= '0;
            r_c_addr   <= '0;
            r_d_issue  <= '0;
            r_cfg_err  <= 1'b0;
        end else if (w_start_ok) begin
            r_bank_a   <= a_base[AW+1:AW];
            r_bank_b   <= b_base[AW+1:AW];
            r_bank_c   <= c_base[AW+1:AW];
            r_bank_d   <= d_base[AW+1:AW];
            r_b_off    <= b_base[AW-1:0];
            r_a_stride <= a_stride;
            r_c_stride <= c_stride;
            r_d_stride <= d_stride;
            r_rows     <= rows;
            r_cols     <= cols;
            r_i        <= '0;
            r_j        <= '0;
            r_a_row    <= a_base[AW-1:0];
            r_c_row    <= c_base[AW-1:0];
            r_d_row    <= d_base[AW-1:0];
            r_cfg_err  <= !w_bank_ok;
            // Visible addresses only move when a real operation begins.
            if (w_bank_ok && !w_empty) begin
                r_a_addr  <= a_base;
                r_b_addr  <= b_base;
                r_c_addr  <= c_base;
                r_d_issue <= d_base;
            end
        end else if (w_issue && !w_last) begin
            r_a_addr  <= {r_bank_a, w_a_nxt};
            r_b_addr  <= {r_bank_b, w_b_nxt};
            r_c_addr  <= {r_bank_c, w_c_nxt};
            r_d_issue <= {r_bank_d, w_d_nxt};
            if (w_last_col) begin
                r_j     <= '0;
                r_i     <= r_i + 1'b1;
                r_a_row <= w_a_nxt;
                r_c_row <= w_c_nxt;
                r_d_row <= w_d_nxt;
            end else begin
                r_j <= w_j_inc;
            end
        end
    end

    addr_delay_line #(
        .DEPTH (PIPE_DEPTH),
        .AW    (BW)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_adv  (!stall),
        .i_vld  (w_issue),
        .i_addr (r_d_issue),
        .o_vld  (w_dl_vld),
        .o_addr (w_dl_addr)
    );

    // Empty after this edge: only the last stage may hold a write, and it drains now.
    assign w_drain_ok = (w_dl_vld == '0) || ((w_dl_vld == LAST_MASK) && !stall);
    assign w_wr       = w_dl_vld[PIPE_DEPTH-1] && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_d_hold <= '0;
        else if (w_wr) r_d_hold <= w_dl_addr;
    end

    assign A_addr   = r_a_addr;
    assign B_addr   = r_b_addr;
    assign C_addr   = r_c_addr;
    assign D_addr   = w_wr ? w_dl_addr : r_d_hold;
    assign rd_valid = w_issue;
    assign d_wr_en  = w_wr;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign cfg_err  = (r_state == ST_DONE) && r_cfg_err;

endmodule
